// File: rtl/seg7_pkg.sv
// Shared constants for the countdown digit bus and the 7-segment display side.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int NUM_DIGITS = 6;

   typedef logic [3:0] code_t;
   typedef logic [6:0] pat_t;

   localparam code_t CODE_F    = 4'hA;
   localparam code_t CODE_U    = 4'hB;
   localparam code_t CODE_C    = 4'hC;
   localparam code_t CODE_DASH = 4'hD;

   localparam pat_t PAT_0     = 7'h3F;
   localparam pat_t PAT_1     = 7'h06;
   localparam pat_t PAT_2     = 7'h5B;
   localparam pat_t PAT_3     = 7'h4F;
   localparam pat_t PAT_4     = 7'h66;
   localparam pat_t PAT_5     = 7'h6D;
   localparam pat_t PAT_6     = 7'h7D;
   localparam pat_t PAT_7     = 7'h07;
   localparam pat_t PAT_8     = 7'h7F;
   localparam pat_t PAT_9     = 7'h6F;
   localparam pat_t PAT_F     = 7'h71;
   localparam pat_t PAT_U     = 7'h3E;
   localparam pat_t PAT_C     = 7'h39;
   localparam pat_t PAT_DASH  = 7'h40;
   localparam pat_t PAT_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit display code to active-high {g,f,e,d,c,b,a} pattern.
// Codes E and F render blank.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = PAT_BLANK;
      case (code)
         4'h0:      pattern = PAT_0;
         4'h1:      pattern = PAT_1;
         4'h2:      pattern = PAT_2;
         4'h3:      pattern = PAT_3;
         4'h4:      pattern = PAT_4;
         4'h5:      pattern = PAT_5;
         4'h6:      pattern = PAT_6;
         4'h7:      pattern = PAT_7;
         4'h8:      pattern = PAT_8;
         4'h9:      pattern = PAT_9;
         CODE_F:    pattern = PAT_F;
         CODE_U:    pattern = PAT_U;
         CODE_C:    pattern = PAT_C;
         CODE_DASH: pattern = PAT_DASH;
         default:   pattern = PAT_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment driver: prescaled slot scan, per-frame input
// snapshot, message mode, decimal points, anti-ghost dead time and blink.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int DEAD_CYC    = 64,
   parameter int BLINK_SLOTS = 1200,
   parameter bit SEG_ACT_LOW = 1'b1,
   parameter bit AN_ACT_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] min,
   input  logic [3:0] seg2,
   input  logic [3:0] seg1,
   input  logic [3:0] deci,
   input  logic [3:0] centi,
   input  logic [3:0] milli,
   input  logic       blink_en,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

   logic [PW-1:0] pcnt;
   logic [2:0]    idx;
   logic [BW-1:0] bcnt;
   logic          bphase;
   logic          tick;
   logic [3:0]    snap [NUM_DIGITS];

   logic [3:0]    cur_code;
   logic [6:0]    cur_pat;
   logic          msg;
   logic          out_en;
   logic [6:0]    seg_hi;
   logic          dp_hi;
   logic [5:0]    an_hi;

   assign tick = (pcnt == PW'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pcnt   <= '0;
         idx    <= '0;
         bcnt   <= '0;
         bphase <= 1'b1;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (tick) begin
            idx <= (idx == 3'd5) ? '0 : idx + 3'd1;
            if (bcnt == BW'(BLINK_SLOTS - 1)) begin
               bcnt   <= '0;
               bphase <= ~bphase;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
      end
   end

   // All six digits latch together at the frame wrap so a frame never tears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
      end else if (tick && idx == 3'd5) begin
         snap[5] <= min;
         snap[4] <= seg2;
         snap[3] <= seg1;
         snap[2] <= deci;
         snap[1] <= centi;
         snap[0] <= milli;
      end
   end

   always_comb begin
      cur_code = '0;
      case (idx)
         3'd0:    cur_code = snap[0];
         3'd1:    cur_code = snap[1];
         3'd2:    cur_code = snap[2];
         3'd3:    cur_code = snap[3];
         3'd4:    cur_code = snap[4];
         3'd5:    cur_code = snap[5];
         default: cur_code = '0;
      endcase
   end

   seg7_decode u_decode (
      .code    (cur_code),
      .pattern (cur_pat)
   );

   always_comb begin
      msg    = (snap[5] == CODE_F);
      out_en = (pcnt >= PW'(DEAD_CYC)) && !(blink_en && !bphase);
      seg_hi = '0;
      dp_hi  = 1'b0;
      an_hi  = '0;
      if (out_en) begin
         an_hi  = 6'b1 << idx;
         seg_hi = (msg && (idx == 3'd0 || idx == 3'd1)) ? PAT_BLANK : cur_pat;
         dp_hi  = !msg && (idx == 3'd5 || idx == 3'd3);
      end
   end

   // Polarity is applied only here; everything upstream is active-high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg <= {7{SEG_ACT_LOW}};
         dp  <= SEG_ACT_LOW;
         an  <= {6{AN_ACT_LOW}};
      end else begin
         seg <= seg_hi ^ {7{SEG_ACT_LOW}};
         dp  <= dp_hi ^ SEG_ACT_LOW;
         an  <= an_hi ^ {6{AN_ACT_LOW}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded bench for seg7_scan_driver (SCAN_DIV=8, DEAD_CYC=2, BLINK_SLOTS=3,
// active-low), with a time-based reference model of the display.
module tb_seg7_scan_driver;

   localparam int SD   = 8;
   localparam int DEAD = 2;
   localparam int BS   = 3;
   localparam logic [13:0] BLANK_EXP = {6'h3F, 7'h7F, 1'b1};

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] min, seg2, seg1, deci, centi, milli;
   logic       blink_en;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;

   int checks = 0;
   int fails  = 0;

   logic [13:0] exp_q [$];

   // Model state: cycles since reset release and the digits currently shown.
   int         t = 0;
   logic [3:0] shown [6];

   seg7_scan_driver #(
      .SCAN_DIV    (SD),
      .DEAD_CYC    (DEAD),
      .BLINK_SLOTS (BS),
      .SEG_ACT_LOW (1'b1),
      .AN_ACT_LOW  (1'b1)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .min      (min),
      .seg2     (seg2),
      .seg1     (seg1),
      .deci     (deci),
      .centi    (centi),
      .milli    (milli),
      .blink_en (blink_en),
      .seg      (seg),
      .dp       (dp),
      .an       (an)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] low_pattern(input logic [3:0] code);
      case (code)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001110;
         4'hB: return 7'b1000001;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   // Reference model: from the cycle count, which slot/phase we are in.
   always @(posedge clk) begin
      if (!reset_n) begin
         t = 0;
         for (int i = 0; i < 6; i++) shown[i] = 4'h0;
         exp_q.push_back(BLANK_EXP);
      end else begin
         int slot, pos, ix;
         bit on, blink_visible, message;
         logic [13:0] e;
         slot = t / SD;
         pos  = t % SD;
         ix   = slot % 6;
         blink_visible = ((slot / BS) % 2) == 0;
         on = (pos >= DEAD) && !(blink_en && !blink_visible);
         message = (shown[5] == 4'hA);
         e = BLANK_EXP;
         if (on) begin
            e[13:8] = ~(6'b1 << ix);
            e[7:1]  = (message && ix < 2) ? 7'b1111111 : low_pattern(shown[ix]);
            e[0]    = !(!message && (ix == 5 || ix == 3));
         end
         exp_q.push_back(e);
         if (pos == SD - 1 && ix == 5) begin
            shown[5] = min;  shown[4] = seg2;  shown[3] = seg1;
            shown[2] = deci; shown[1] = centi; shown[0] = milli;
         end
         t = t + 1;
      end
   end

   // Monitor: the DUT presents a new output word every cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [13:0] e;
         e = exp_q.pop_front();
         checks++;
         if ({an, seg, dp} !== e) begin
            fails++;
            $display("FAIL scan t=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     t, an, seg, dp, e[13:8], e[7:1], e[0]);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
      min = a; seg2 = b; seg1 = c; deci = d; centi = e; milli = f;
   endtask

   task automatic check_now(input string name, input logic [13:0] want);
      checks++;
      if ({an, seg, dp} !== want) begin
         fails++;
         $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                  name, an, seg, dp, want[13:8], want[7:1], want[0]);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check_now("reset_hold", BLANK_EXP);
      cycles(3);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n  = 1'b0;
      blink_en = 1'b0;
      set_digits(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
      cycles(1);
      do_reset();

      // Scan order over two frames, then a mid-frame change (idx2) of milli.
      cycles(96 + 20);
      milli = 4'h7;
      cycles(28 + 48 + 10);

      set_digits(4'hA, 4'hB, 4'hC, 4'hC, 4'h0, 4'h0);
      cycles(110);

      blink_en = 1'b1;
      cycles(48 * 3);
      blink_en = 1'b0;
      cycles(60);

      for (int r = 0; r < 40; r++) begin
         set_digits(4'($urandom), 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom), 4'($urandom));
         if ($urandom_range(0, 4) == 0) min = 4'hA;
         blink_en = ($urandom_range(0, 3) == 0);
         cycles($urandom_range(5, 60));
      end

      // Async reset at idx3, pcnt=4 of the first frame after a fresh reset.
      blink_en = 1'b0;
      set_digits(4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4);
      do_reset();
      cycles(28);
      #2;
      reset_n = 1'b0;
      #1;
      check_now("async_reset", BLANK_EXP);
      cycles(3);
      reset_n = 1'b1;
      cycles(110);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
